// File: rtl/lsab_pkg.sv
// Shared types and constants for the host-side LSAB channel: FSM states,
// field widths and the bit positions inside the CPU-visible status byte.
package lsab_pkg;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 24;
  localparam int TURN_W = 2;
  localparam int ANC_W  = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_XFER,
    ST_DONE
  } ph_state_t;

  localparam int STS_BUSY     = 7;
  localparam int STS_DONE     = 6;
  localparam int STS_ERR      = 5;
  localparam int STS_OVF      = 4;
  localparam int STS_UNF      = 3;
  localparam int STS_IRQ      = 2;
  localparam int STS_TX_EMPTY = 1;
  localparam int STS_RX_EMPTY = 0;

endpackage

// File: rtl/lsab_host_channel_if.sv
// Device-facing LSAB channel bus. The host drives turns, phase control and
// read data; the device drives strobes, write data, interrupt and error.
interface lsab_host_channel_if;
  import lsab_pkg::*;

  logic [TURN_W-1:0] turn_cr;
  logic [TURN_W-1:0] turn_cw;
  logic [DATA_W-1:0] data_cr;
  logic              write_cr;
  logic [ANC_W-1:0]  ancill_cr;
  logic              int_cr;
  logic              read_cw;
  logic [DATA_W-1:0] data_cw;
  logic              err_cw;
  logic              errack_cw;
  logic [LEN_W-1:0]  ph_len;
  logic              ph_dir;
  logic              ph_enstb;

  modport master (
    output turn_cr, turn_cw, data_cw, errack_cw, ph_len, ph_dir, ph_enstb,
    input  data_cr, write_cr, ancill_cr, int_cr, read_cw, err_cw
  );

  modport slave (
    input  turn_cr, turn_cw, data_cw, errack_cw, ph_len, ph_dir, ph_enstb,
    output data_cr, write_cr, ancill_cr, int_cr, read_cw, err_cw
  );

endinterface

// File: rtl/lsab_sync_fifo.sv
// Single-clock FIFO with a registered head word (0 while empty) and a
// synchronous flush. A push into a full FIFO or a pop from an empty one is ignored.
module lsab_sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              CLK_n,
  input  logic              RST,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wPtr;
  logic [DEPTH_LOG2-1:0] rPtr;
  logic [DEPTH_LOG2-1:0] rPtrNext;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   countNext;
  logic                  doPush;
  logic                  doPop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign rPtrNext = doPop ? rPtr + DEPTH_LOG2'(1) : rPtr;

  always_comb begin
    countNext = count;
    if (doPush && !doPop) countNext = count + (DEPTH_LOG2 + 1)'(1);
    if (!doPush && doPop) countNext = count - (DEPTH_LOG2 + 1)'(1);
  end

  always_ff @(posedge CLK_n) begin
    if (doPush) mem[wPtr] <= wdata;
  end

  // Head is precomputed for the next cycle; a word pushed into the slot that
  // becomes the head has not reached mem yet, so it is forwarded from wdata.
  always_ff @(posedge CLK_n) begin
    if (!RST || flush) begin
      wPtr  <= '0;
      rPtr  <= '0;
      count <= '0;
      head  <= '0;
    end else begin
      if (doPush) wPtr <= wPtr + DEPTH_LOG2'(1);
      rPtr  <= rPtrNext;
      count <= countNext;
      if (countNext == '0)
        head <= '0;
      else if (doPush && (rPtrNext == wPtr))
        head <= wdata;
      else
        head <= mem[rPtrNext];
    end
  end

endmodule

// File: rtl/lsab_host_channel.sv
// Host end of one LSAB peripheral channel: turn counters, phase FSM, and
// RX/TX FIFOs between the CPU register side and the device.
module lsab_host_channel
  import lsab_pkg::*;
#(
  parameter int CHAN_ID    = 0,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               CLK_n,
  input  logic               RST,
  input  logic               cpu_push,
  input  logic [DATA_W-1:0]  cpu_wdata,
  input  logic               cpu_pop,
  output logic [DATA_W-1:0]  cpu_rdata,
  input  logic               cpu_start,
  input  logic [LEN_W-1:0]   cpu_len,
  input  logic               cpu_dir,
  output logic [7:0]         status,
  output logic [ANC_W-1:0]   irq_ancill,
  lsab_host_channel_if.master bus
);

  localparam logic [TURN_W-1:0] SLOT = TURN_W'(CHAN_ID);

  ph_state_t         state;
  logic [TURN_W-1:0] turnCr;
  logic [TURN_W-1:0] turnCw;
  logic [LEN_W-1:0]  phLen;
  logic              phDir;
  logic              enStb;
  logic              errAck;
  logic              errPrev;
  logic              doneF, errF, ovfF, unfF, irqF;
  logic              rxFull, rxEmpty, txFull, txEmpty;
  logic              wrOk, rdOk, rxOvf, txUnf, countOk, startOk;

  always_ff @(posedge CLK_n) begin
    if (!RST) turnCr <= '0;
    else      turnCr <= turnCr + TURN_W'(1);
  end

  // turn_cw is turn_cr delayed by one, which is the same as one behind it.
  assign turnCw = turnCr - TURN_W'(1);

  assign wrOk    = bus.write_cr && (turnCr == SLOT);
  assign rdOk    = bus.read_cw && (turnCw == SLOT);
  assign rxOvf   = wrOk && rxFull;
  assign txUnf   = rdOk && txEmpty;
  assign startOk = cpu_start && (state == ST_IDLE) && !bus.err_cw;
  assign countOk = (state == ST_XFER) &&
                   (phDir ? (rdOk && !txEmpty) : (wrOk && !rxFull));

  lsab_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) rxFifo (
    .CLK_n (CLK_n),
    .RST   (RST),
    .flush (1'b0),
    .push  (wrOk),
    .wdata (bus.data_cr),
    .pop   (cpu_pop),
    .full  (rxFull),
    .empty (rxEmpty),
    .head  (cpu_rdata)
  );

  lsab_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) txFifo (
    .CLK_n (CLK_n),
    .RST   (RST),
    .flush (bus.err_cw),
    .push  (cpu_push),
    .wdata (cpu_wdata),
    .pop   (rdOk),
    .full  (txFull),
    .empty (txEmpty),
    .head  (bus.data_cw)
  );

  always_ff @(posedge CLK_n) begin
    if (!RST) begin
      state      <= ST_IDLE;
      phLen      <= '0;
      phDir      <= 1'b0;
      enStb      <= 1'b0;
      errAck     <= 1'b0;
      errPrev    <= 1'b0;
      doneF      <= 1'b0;
      errF       <= 1'b0;
      ovfF       <= 1'b0;
      unfF       <= 1'b0;
      irqF       <= 1'b0;
      irq_ancill <= '0;
    end else begin
      // errack answers only the rising edge of err_cw.
      errPrev <= bus.err_cw;
      errAck  <= bus.err_cw && !errPrev;
      errF    <= (errF && !startOk) || bus.err_cw;
      ovfF    <= (ovfF && !startOk) || rxOvf;
      unfF    <= (unfF && !startOk) || txUnf;
      irqF    <= (irqF && !startOk) || bus.int_cr;
      if (bus.int_cr) irq_ancill <= bus.ancill_cr;
      enStb <= 1'b0;

      if (bus.err_cw) begin
        state <= ST_IDLE;
        phLen <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (startOk) begin
              doneF <= 1'b0;
              phDir <= cpu_dir;
              if (cpu_len != '0) begin
                phLen <= cpu_len;
                enStb <= 1'b1;
                state <= ST_ARM;
              end else begin
                doneF <= 1'b1;
                state <= ST_DONE;
              end
            end
          end
          ST_ARM:  state <= ST_XFER;
          ST_XFER: begin
            if (countOk) begin
              phLen <= phLen - LEN_W'(1);
              if (phLen == LEN_W'(1)) begin
                doneF <= 1'b1;
                state <= ST_DONE;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.turn_cr   = turnCr;
  assign bus.turn_cw   = turnCw;
  assign bus.errack_cw = errAck;
  assign bus.ph_len    = phLen;
  assign bus.ph_dir    = phDir;
  assign bus.ph_enstb  = enStb;

  always_comb begin
    status               = '0;
    status[STS_BUSY]     = (state != ST_IDLE);
    status[STS_DONE]     = doneF;
    status[STS_ERR]      = errF;
    status[STS_OVF]      = ovfF;
    status[STS_UNF]      = unfF;
    status[STS_IRQ]      = irqF;
    status[STS_TX_EMPTY] = txEmpty;
    status[STS_RX_EMPTY] = rxEmpty;
  end

endmodule

// File: tb/tb_lsab_host_channel.sv
// Bench for lsab_host_channel: channel 1 and channel 2 instances share all
// inputs; each test resets both and checks the instance it targets.
module tb_lsab_host_channel;

  logic        CLK_n;
  logic        RST;
  logic        cpu_push;
  logic [31:0] cpu_wdata;
  logic        cpu_pop;
  logic        cpu_start;
  logic [23:0] cpu_len;
  logic        cpu_dir;
  logic [31:0] rdataA, rdataB;
  logic [7:0]  statusA, statusB;
  logic [24:0] ancA, ancB;

  int total = 0;
  int bad   = 0;

  lsab_host_channel_if busA();
  lsab_host_channel_if busB();

  assign busB.data_cr   = busA.data_cr;
  assign busB.write_cr  = busA.write_cr;
  assign busB.ancill_cr = busA.ancill_cr;
  assign busB.int_cr    = busA.int_cr;
  assign busB.read_cw   = busA.read_cw;
  assign busB.err_cw    = busA.err_cw;

  lsab_host_channel #(.CHAN_ID(1), .DEPTH_LOG2(4)) dutA (
    .CLK_n(CLK_n), .RST(RST), .cpu_push(cpu_push), .cpu_wdata(cpu_wdata),
    .cpu_pop(cpu_pop), .cpu_rdata(rdataA), .cpu_start(cpu_start),
    .cpu_len(cpu_len), .cpu_dir(cpu_dir), .status(statusA),
    .irq_ancill(ancA), .bus(busA)
  );

  lsab_host_channel #(.CHAN_ID(2), .DEPTH_LOG2(4)) dutB (
    .CLK_n(CLK_n), .RST(RST), .cpu_push(cpu_push), .cpu_wdata(cpu_wdata),
    .cpu_pop(cpu_pop), .cpu_rdata(rdataB), .cpu_start(cpu_start),
    .cpu_len(cpu_len), .cpu_dir(cpu_dir), .status(statusB),
    .irq_ancill(ancB), .bus(busB)
  );

  initial CLK_n = 1'b0;
  always #5 CLK_n = ~CLK_n;

  typedef struct {
    string tag;
    int rst, sel, push, wd, start, len, dir, pop, rd, wr, dcr;
    int eDcw, eRd, eLen, eStb, eSt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string tag, int rst, int sel, int push, int wd,
                              int start, int len, int dir, int pop, int rd,
                              int wr, int dcr, int eDcw, int eRd, int eLen,
                              int eStb, int eSt);
    vec_t v;
    v.tag = tag; v.rst = rst; v.sel = sel; v.push = push; v.wd = wd;
    v.start = start; v.len = len; v.dir = dir; v.pop = pop; v.rd = rd;
    v.wr = wr; v.dcr = dcr; v.eDcw = eDcw; v.eRd = eRd; v.eLen = eLen;
    v.eStb = eStb; v.eSt = eSt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_n);
    #1;
  endtask

  task automatic clearIn();
    cpu_push = 1'b0; cpu_wdata = '0; cpu_pop = 1'b0; cpu_start = 1'b0;
    cpu_len = '0; cpu_dir = 1'b0;
    busA.data_cr = '0; busA.write_cr = 1'b0; busA.ancill_cr = '0;
    busA.int_cr = 1'b0; busA.read_cw = 1'b0; busA.err_cw = 1'b0;
  endtask

  // Leaves RST released #1 after the last reset edge, with turn_cr=0.
  task automatic doReset();
    clearIn();
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic checkResetA(input string t);
    check({t, " turn_cr"},    32'(busA.turn_cr),   32'd0);
    check({t, " turn_cw"},    32'(busA.turn_cw),   32'd3);
    check({t, " ph_len"},     32'(busA.ph_len),    32'd0);
    check({t, " ph_dir"},     32'(busA.ph_dir),    32'd0);
    check({t, " ph_enstb"},   32'(busA.ph_enstb),  32'd0);
    check({t, " errack_cw"},  32'(busA.errack_cw), 32'd0);
    check({t, " status"},     32'(statusA),        32'h03);
    check({t, " irq_ancill"}, 32'(ancA),           32'd0);
    check({t, " cpu_rdata"},  rdataA,              32'd0);
    check({t, " data_cw"},    busA.data_cw,        32'd0);
  endtask

  // Waits until channel 1's receive (useCw=0) or send (useCw=1) slot is current.
  task automatic waitSlotA(input bit useCw);
    int n = 0;
    while ((useCw ? busA.turn_cw : busA.turn_cr) != 2'd1 && n < 8) begin
      tick();
      n++;
    end
    total++;
    if (n >= 8) begin
      bad++;
      $display("FAIL slot_wait actual=timeout required=slot1");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    RST = 1'b0;
    clearIn();
    tick();
    tick();
    checkResetA("reset");

    // TX phase on channel 1 (read slot when edge index %4 == 2), then
    // RX phase on channel 2 (write slot when edge index %4 == 2).
    //                 tag    rst sel push wd     st len dir pop rd wr dcr    eDcw   eRd    eLen stb eSt
    vecs.push_back(mk("t1r0",  1, 0, 1, 'hA,     0, 0, 0, 0, 0, 0, 0,      'hA,   0,     0,   0, 'h01));
    vecs.push_back(mk("t1r1",  0, 0, 1, 'hB,     0, 0, 0, 0, 0, 0, 0,      'hA,   0,     0,   0, 'h01));
    vecs.push_back(mk("t1r2",  0, 0, 1, 'hC,     0, 0, 0, 0, 0, 0, 0,      'hA,   0,     0,   0, 'h01));
    vecs.push_back(mk("t1r3",  0, 0, 0, 0,       1, 3, 1, 0, 0, 0, 0,      'hA,   0,     3,   1, 'h81));
    vecs.push_back(mk("t1r4",  0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0,      'hA,   0,     3,   0, 'h81));
    vecs.push_back(mk("t1r5",  0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0,      'hA,   0,     3,   0, 'h81));
    vecs.push_back(mk("t1r6",  0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 0,      'hB,   0,     2,   0, 'h81));
    vecs.push_back(mk("t1r7",  0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 0,      'hB,   0,     2,   0, 'h81));
    vecs.push_back(mk("t1r8",  0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0,      'hB,   0,     2,   0, 'h81));
    vecs.push_back(mk("t1r9",  0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0,      'hB,   0,     2,   0, 'h81));
    vecs.push_back(mk("t1r10", 0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 0,      'hC,   0,     1,   0, 'h81));
    vecs.push_back(mk("t1r11", 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0,      'hC,   0,     1,   0, 'h81));
    vecs.push_back(mk("t1r12", 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0,      'hC,   0,     1,   0, 'h81));
    vecs.push_back(mk("t1r13", 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0,      'hC,   0,     1,   0, 'h81));
    vecs.push_back(mk("t1r14", 0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 0,      0,     0,     0,   0, 'hC3));
    vecs.push_back(mk("t1r15", 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0,      0,     0,     0,   0, 'h43));
    vecs.push_back(mk("t2r0",  1, 1, 0, 0,       1, 2, 0, 0, 0, 0, 0,      0,     0,     2,   1, 'h83));
    vecs.push_back(mk("t2r1",  0, 1, 0, 0,       0, 0, 0, 0, 0, 1, 'h11,   0,     0,     2,   0, 'h83));
    vecs.push_back(mk("t2r2",  0, 1, 0, 0,       0, 0, 0, 0, 0, 1, 'h22,   0,     'h22,  1,   0, 'h82));
    vecs.push_back(mk("t2r3",  0, 1, 0, 0,       0, 0, 0, 0, 0, 0, 0,      0,     'h22,  1,   0, 'h82));
    vecs.push_back(mk("t2r4",  0, 1, 0, 0,       0, 0, 0, 0, 0, 0, 0,      0,     'h22,  1,   0, 'h82));
    vecs.push_back(mk("t2r5",  0, 1, 0, 0,       0, 0, 0, 0, 0, 0, 0,      0,     'h22,  1,   0, 'h82));
    vecs.push_back(mk("t2r6",  0, 1, 0, 0,       0, 0, 0, 0, 0, 1, 'h33,   0,     'h22,  0,   0, 'hC2));
    vecs.push_back(mk("t2r7",  0, 1, 0, 0,       0, 0, 0, 1, 0, 0, 0,      0,     'h33,  0,   0, 'h42));
    vecs.push_back(mk("t2r8",  0, 1, 0, 0,       0, 0, 0, 1, 0, 0, 0,      0,     0,     0,   0, 'h43));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      if (v.rst != 0) doReset();
      cpu_push      = 1'(v.push);
      cpu_wdata     = 32'(v.wd);
      cpu_start     = 1'(v.start);
      cpu_len       = 24'(v.len);
      cpu_dir       = 1'(v.dir);
      cpu_pop       = 1'(v.pop);
      busA.read_cw  = 1'(v.rd);
      busA.write_cr = 1'(v.wr);
      busA.data_cr  = 32'(v.dcr);
      tick();
      if (v.sel == 0) begin
        check({v.tag, " data_cw"},   busA.data_cw,         32'(v.eDcw));
        check({v.tag, " cpu_rdata"}, rdataA,               32'(v.eRd));
        check({v.tag, " ph_len"},    32'(busA.ph_len),     32'(v.eLen));
        check({v.tag, " ph_enstb"},  32'(busA.ph_enstb),   32'(v.eStb));
        check({v.tag, " status"},    32'(statusA),         32'(v.eSt));
      end else begin
        check({v.tag, " data_cw"},   busB.data_cw,         32'(v.eDcw));
        check({v.tag, " cpu_rdata"}, rdataB,               32'(v.eRd));
        check({v.tag, " ph_len"},    32'(busB.ph_len),     32'(v.eLen));
        check({v.tag, " ph_enstb"},  32'(busB.ph_enstb),   32'(v.eStb));
        check({v.tag, " status"},    32'(statusB),         32'(v.eSt));
      end
    end
    clearIn();

    // RX overflow: 17 in-slot writes into the 16-deep FIFO, phase length 20.
    doReset();
    cpu_start = 1'b1; cpu_len = 24'd20; cpu_dir = 1'b0;
    tick();
    cpu_start = 1'b0;
    tick();
    for (int k = 0; k < 17; k++) begin
      waitSlotA(1'b0);
      busA.write_cr = 1'b1;
      busA.data_cr  = 32'(100 + k);
      tick();
      busA.write_cr = 1'b0;
      if (k == 15) begin
        check("ovf before 17th", 32'(statusA[4]), 32'd0);
        check("len after 16",    32'(busA.ph_len), 32'd4);
      end
    end
    check("ovf after 17th",  32'(statusA[4]),  32'd1);
    check("len after 17",    32'(busA.ph_len), 32'd4);
    check("rx head first",   rdataA,           32'd100);
    cpu_pop = 1'b1;
    repeat (15) tick();
    cpu_pop = 1'b0;
    check("rx head 16th",    rdataA,           32'd115);
    cpu_pop = 1'b1;
    tick();
    cpu_pop = 1'b0;
    check("rx empty after 16 pops", 32'(statusA[0]), 32'd1);

    // Collision mid-TX: 5 words queued, one read, then err_cw for 3 cycles.
    doReset();
    for (int k = 0; k < 5; k++) begin
      cpu_push = 1'b1; cpu_wdata = 32'(32'h50 + k);
      tick();
    end
    cpu_push = 1'b0;
    cpu_start = 1'b1; cpu_len = 24'd5; cpu_dir = 1'b1;
    tick();
    cpu_start = 1'b0;
    tick();
    waitSlotA(1'b1);
    busA.read_cw = 1'b1;
    tick();
    busA.read_cw = 1'b0;
    check("err pre data_cw", busA.data_cw,     32'h51);
    check("err pre ph_len",  32'(busA.ph_len), 32'd4);
    pulses = 0;
    busA.err_cw = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) busA.err_cw = 1'b0;
      tick();
      if (busA.errack_cw) pulses++;
    end
    check("errack pulses",   32'(pulses),       32'd1);
    check("err status",      32'(statusA),      32'h23);
    check("err ph_len",      32'(busA.ph_len),  32'd0);
    check("err data_cw",     busA.data_cw,      32'd0);

    // Interrupt capture and clear by the next start (zero-length phase).
    doReset();
    busA.ancill_cr = 25'h1ABCDEF;
    busA.int_cr = 1'b1;
    tick();
    busA.int_cr = 1'b0;
    busA.ancill_cr = '0;
    check("irq_ancill",      32'(ancA),        32'h1ABCDEF);
    check("irq set",         32'(statusA[2]),  32'd1);
    cpu_start = 1'b1; cpu_len = 24'd0;
    tick();
    cpu_start = 1'b0;
    check("irq cleared",     32'(statusA[2]),  32'd0);
    check("len0 done",       32'(statusA[6]),  32'd1);
    tick();
    check("len0 idle",       32'(statusA),     32'h43);

    // Reset in the middle of a TX phase, with err_cw raised at the same edge.
    doReset();
    cpu_push = 1'b1; cpu_wdata = 32'hDEAD;
    busA.ancill_cr = 25'h155; busA.int_cr = 1'b1;
    tick();
    cpu_push = 1'b0; busA.int_cr = 1'b0;
    cpu_start = 1'b1; cpu_len = 24'd5; cpu_dir = 1'b1;
    tick();
    cpu_start = 1'b0;
    tick();
    waitSlotA(1'b0);
    busA.write_cr = 1'b1; busA.data_cr = 32'h77;
    tick();
    busA.write_cr = 1'b0;
    check("pre-reset wrong-dir len", 32'(busA.ph_len), 32'd5);
    check("pre-reset rdata",         rdataA,           32'h77);
    check("pre-reset data_cw",       busA.data_cw,     32'hDEAD);
    RST = 1'b0;
    busA.err_cw = 1'b1;
    tick();
    checkResetA("midreset");
    RST = 1'b1;
    busA.err_cw = 1'b0;
    tick();
    check("post-reset errack", 32'(busA.errack_cw), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsab_host_channel.md
# lsab_host_channel

Host-side end of one LSAB peripheral channel. It drives the turn counters, phase length, direction and start strobe toward a device such as the Ethernet block. It accepts device writes (write_cr/data_cr/int_cr/ancill_cr) into a receive FIFO and serves device reads (read_cw/data_cw) from a transmit FIFO. It sits beside the CPU-side register interface and is the counterpart of every device-side LSAB port.

## Interface
- CHAN_ID, 0: slot number (0..3) this channel owns in the turn rotation
- DEPTH_LOG2, 4: log2 of each FIFO depth (16 words)
- CLK_n  in  1  system clock; one clock domain
- RST  in  1  synchronous, active-low reset
- cpu_push  in  1  push cpu_wdata into TX FIFO
- cpu_wdata  in  32  word for device
- cpu_pop  in  1  pop RX FIFO head
- cpu_rdata  out  32  RX FIFO head (0 when empty)
- cpu_start  in  1  start phase
- cpu_len  in  24  phase length in words
- cpu_dir  in  1  1 = host→device (TX), 0 = device→host (RX)
- status  out  8  {busy, done, err, ovf, unf, irq, tx_empty, rx_empty}
- irq_ancill  out  25  ancill_cr captured on last int_cr
- turn_cr  out  2  receive-turn counter to device
- turn_cw  out  2  send-turn counter to device
- data_cr  in  32  device write data
- write_cr  in  1  device write strobe
- ancill_cr  in  25  device ancillary word
- int_cr  in  1  device interrupt
- read_cw  in  1  device read strobe
- data_cw  out  32  TX FIFO head to device
- err_cw  in  1  device error (collision)
- errack_cw  out  1  error acknowledge
- ph_len  out  24  remaining phase length
- ph_dir  out  1  phase direction
- ph_enstb  out  1  phase enable strobe

## Operation
- turn_cr and turn_cw: free-running 2-bit counters, +1 every cycle, wrap 3→0. turn_cw lags turn_cr by 1. Slot is valid when the counter equals CHAN_ID.
- Device strobes are honoured only in the matching slot: write_cr when turn_cr==CHAN_ID, read_cw when turn_cw==CHAN_ID. Strobes outside the slot are ignored.
- FSM IDLE→ARM→XFER→DONE→IDLE.
  - IDLE: cpu_start with cpu_len≠0 loads ph_len/ph_dir and goes to ARM. cpu_len=0 goes straight to DONE.
  - ARM: ph_enstb=1 for exactly one cycle, then XFER.
  - XFER: each accepted strobe in the programmed direction decrements ph_len. ph_len reaching 0 goes to DONE.
  - DONE: sets status.done (sticky until the next cpu_start), then IDLE.
- Strobes in the wrong direction are accepted into or out of their FIFO but do not decrement ph_len.
- RX FIFO full plus an accepted write_cr: the word is dropped and ovf is set (sticky). TX FIFO empty plus an accepted read_cw: data_cw=0 and unf is set (sticky). Neither event decrements ph_len.
- int_cr=1: captures ancill_cr into irq_ancill and sets irq (sticky). Sticky flags clear on cpu_start.
- err_cw=1 in any state:
  - errack_cw=1 on the next cycle, for 1 cycle; it is re-asserted only after err_cw has deasserted.
  - Sets err.
  - Flushes the TX FIFO.
  - Returns the FSM to IDLE with ph_len=0.
- cpu_start while busy is ignored.
- Simultaneous push and pop on the same FIFO, not full and not empty: both occur and the count is unchanged.

## Timing
- Reset: all FIFOs empty; turn_cr=0, turn_cw=3; ph_len=0, ph_dir=0, ph_enstb=0, errack_cw=0, status=8'b0000_0011, irq_ancill=0, cpu_rdata=0, data_cw=0.
- data_cw is the registered FIFO head. It is valid from the cycle after the push into an empty FIFO and advances the cycle after an accepted read_cw.
- write_cr to cpu_rdata visibility: 1 cycle.
- cpu_start to ph_enstb: 1 cycle. ph_len updates 1 cycle after each accepted strobe.
- Reset mid-phase: everything returns to reset values in the next cycle, with no errack.

## Structure
- lsab_pkg: FSM state enum, LEN_W=24, TURN_W=2, status bit indices.
- One sub-module, lsab_sync_fifo (parameterised width/depth, full/empty, registered head), instantiated for RX and TX.

## Test plan
- CHAN_ID=1, cpu_dir=1, len=3, push A,B,C. Device pulses read_cw in slots. Required: data_cw A,B,C; ph_len 3→0; done set; ph_enstb exactly one pulse.
- CHAN_ID=2, dir=0, len=2. Device writes 0x11 out of slot, then 0x22 and 0x33 in slots. Required: RX holds only 0x22,0x33; done.
- 17 in-slot writes into the 16-deep RX FIFO. Required: 16 stored, ovf=1, ph_len decremented 16.
- err_cw held 3 cycles mid-TX with 5 words queued. Required: errack_cw one pulse, tx_empty=1, busy=0, err=1.
- int_cr with ancill_cr=0x1ABCDEF. Required: irq_ancill=0x1ABCDEF, irq=1; cleared by next cpu_start.
- RST low during XFER. Required: reset values next cycle, including turn_cr=0 and turn_cw=3.
